// File: rtl/battleship_fire_ctrl.sv
// Shooter-side fire controller: cursor, one-cycle fire request, repeat-shot rejection, shot/hit counts, win/lose.
// Each accepted shot takes one FIRE cycle and one RESP cycle. Buttons are honoured only while IDLE.
module battleship_fire_ctrl #(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int SHIP_CELLS = 4,
  parameter int MAX_SHOTS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_shoot,
  input  logic       hit,
  input  logic [2:0] cell_state,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic       fire,
  output logic       busy,
  output logic       last_hit,
  output logic       repeat_err,
  output logic [7:0] shots,
  output logic [7:0] hits,
  output logic       game_over,
  output logic       win
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [4:0] COL_LAST = 5'(COLS - 1);

  typedef enum logic [1:0] {IDLE, FIRE, RESP, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CELLS-1:0] shot_map;
  logic [IW-1:0]    cell_idx;
  logic             already_shot;
  logic [7:0]       shots_next;
  logic [7:0]       hits_next;
  logic             game_end;
  logic             unused_cell_state;

  // The board's cell code is informational only; nothing here decides on it.
  assign unused_cell_state = ^cell_state;

  assign cell_idx     = IW'(int'(row) * COLS + int'(col));
  assign already_shot = shot_map[cell_idx];
  assign shots_next   = (shots == 8'hFF) ? shots : shots + 8'd1;
  assign hits_next    = (hits == 8'hFF) ? hits : hits + {7'd0, hit};
  assign game_end     = (hits_next == 8'(SHIP_CELLS)) || (shots_next == 8'(MAX_SHOTS));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (btn_shoot && !already_shot) state_next = FIRE;
      FIRE:    state_next = RESP;
      RESP:    state_next = game_end ? DONE : IDLE;
      default: state_next = DONE;
    endcase
  end

  always_comb begin
    fire      = (state == FIRE);
    busy      = (state == FIRE) || (state == RESP);
    game_over = (state == DONE);
    win       = (state == DONE) && (hits == 8'(SHIP_CELLS));
  end

  // Cursor only moves in IDLE and not on a shoot cycle, so it stays frozen through FIRE/RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= 5'd0;
      col <= 5'd0;
    end else if (state == IDLE && !btn_shoot) begin
      if (btn_up && !btn_down)
        row <= (row == 5'd0) ? ROW_LAST : row - 5'd1;
      else if (btn_down && !btn_up)
        row <= (row == ROW_LAST) ? 5'd0 : row + 5'd1;
      if (btn_left && !btn_right)
        col <= (col == 5'd0) ? COL_LAST : col - 5'd1;
      else if (btn_right && !btn_left)
        col <= (col == COL_LAST) ? 5'd0 : col + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shot_map   <= '0;
      repeat_err <= 1'b0;
      shots      <= 8'd0;
      hits       <= 8'd0;
      last_hit   <= 1'b0;
    end else begin
      repeat_err <= 1'b0;
      if (state == IDLE && btn_shoot) begin
        if (already_shot) repeat_err <= 1'b1;
        else              shot_map[cell_idx] <= 1'b1;
      end
      if (state == RESP) begin
        shots    <= shots_next;
        hits     <= hits_next;
        last_hit <= hit;
      end
    end
  end

endmodule

// File: tb/tb_battleship_fire_ctrl.sv
// Scoreboard bench: a board model replies to fire, a game model predicts every fire, repeat and shot result.
module tb_battleship_fire_ctrl;
  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int SHIPS = 4;
  localparam int MAXS  = 15;
  localparam int CELLS = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_shoot = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] cell_state = 3'd0;
  logic [4:0] row, col;
  logic       fire, busy, last_hit, repeat_err, game_over, win;
  logic [7:0] shots, hits;

  always #5 clk = ~clk;

  battleship_fire_ctrl #(.ROWS(ROWS), .COLS(COLS), .SHIP_CELLS(SHIPS), .MAX_SHOTS(MAXS)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_shoot(btn_shoot), .hit(hit), .cell_state(cell_state),
    .row(row), .col(col), .fire(fire), .busy(busy), .last_hit(last_hit),
    .repeat_err(repeat_err), .shots(shots), .hits(hits), .game_over(game_over), .win(win)
  );

  // Board: registered reply one cycle after fire is sampled.
  bit ship [CELLS];
  always @(posedge clk) begin
    hit        <= fire && ship[int'(row) * COLS + int'(col)];
    cell_state <= !fire ? 3'd0 : (ship[int'(row) * COLS + int'(col)] ? 3'd2 : 3'd1);
  end

  typedef struct { int r; int c; } fire_t;
  typedef struct { int shots; int hits; bit last; bit over; bit won; } res_t;
  fire_t fire_q[$];
  res_t  res_q[$];
  int    rep_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model
  int m_row, m_col, m_shots, m_hits, m_busy;
  bit m_done;
  bit m_shot [CELLS];

  task automatic model_clear();
    m_row = 0; m_col = 0; m_shots = 0; m_hits = 0; m_busy = 0; m_done = 0;
    foreach (m_shot[i]) m_shot[i] = 0;
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r, input bit s);
    int idx;
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_shoot = s;
    if (m_busy > 0) begin
      m_busy--;
    end else if (!m_done) begin
      if (s) begin
        idx = m_row * COLS + m_col;
        if (m_shot[idx]) begin
          rep_q.push_back(m_shots);
        end else begin
          m_shot[idx] = 1;
          m_shots++;
          m_hits += ship[idx] ? 1 : 0;
          m_done = (m_hits == SHIPS) || (m_shots == MAXS);
          fire_q.push_back('{m_row, m_col});
          res_q.push_back('{m_shots, m_hits, ship[idx], m_done, m_hits == SHIPS});
          m_busy = 2;
        end
      end else begin
        if (u != d) m_row = u ? (m_row + ROWS - 1) % ROWS : (m_row + 1) % ROWS;
        if (l != r) m_col = l ? (m_col + COLS - 1) % COLS : (m_col + 1) % COLS;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) press(0, 0, 0, 0, 0);
  endtask

  task automatic goto_cell(input int r, input int c);
    for (int i = 0; i < 2 * ROWS && m_row != r; i++) press(1, 0, 0, 0, 0);
    for (int i = 0; i < 2 * COLS && m_col != c; i++) press(0, 0, 0, 1, 0);
  endtask

  task automatic shoot_at(input int r, input int c);
    goto_cell(r, c);
    press(0, 0, 0, 0, 1);
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_shoot = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_clear();
    fire_q.delete(); res_q.delete(); rep_q.delete();
  endtask

  task automatic clear_ships();
    foreach (ship[i]) ship[i] = 0;
  endtask

  // Monitor
  initial begin
    int    pend;
    fire_t f;
    res_t  e;
    int    rs;
    pend = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pend = 0;
      end else begin
        if (pend == 2) begin
          chk("fire_one_cycle", fire, 0);
          chk("busy_in_resp", busy, 1);
          pend = 1;
        end else if (pend == 1) begin
          pend = 0;
          if (res_q.size() == 0) chk("result_expected", 0, 1);
          else begin
            e = res_q.pop_front();
            chk("shots", shots, e.shots);
            chk("hits", hits, e.hits);
            chk("last_hit", last_hit, e.last);
            chk("game_over", game_over, e.over);
            chk("win", win, e.won);
            chk("busy_after_resp", busy, 0);
          end
        end
        if (fire) begin
          if (fire_q.size() == 0) chk("unexpected_fire", fire, 0);
          else begin
            f = fire_q.pop_front();
            chk("fire_row", row, f.r);
            chk("fire_col", col, f.c);
            chk("busy_in_fire", busy, 1);
            pend = 2;
          end
        end
        if (repeat_err) begin
          if (rep_q.size() == 0) chk("unexpected_repeat_err", repeat_err, 0);
          else begin
            rs = rep_q.pop_front();
            chk("repeat_no_fire", fire, 0);
            chk("repeat_shots", shots, rs);
          end
        end
      end
    end
  end

  initial begin
    int k, idx;
    model_clear();
    clear_ships();
    repeat (2) @(negedge clk);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_fire", fire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shots", shots, 0);
    chk("rst_hits", hits, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_win", win, 0);
    chk("rst_repeat_err", repeat_err, 0);
    rst = 1;

    // Cursor wrap
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    idle(1);
    chk("wrap_row", row, 3);
    chk("wrap_row_col", col, 0);
    press(0, 0, 1, 0, 0);
    press(1, 1, 0, 0, 0);
    press(0, 0, 1, 1, 0);
    idle(1);
    chk("wrap_col", col, 4);
    chk("cancel_row", row, 3);

    // Hit, repeat, then win
    ship[2 * COLS + 3] = 1; ship[0] = 1; ship[4 * COLS + 4] = 1; ship[1 * COLS + 2] = 1;
    shoot_at(2, 3);
    press(0, 0, 0, 0, 1);
    idle(2);
    chk("repeat_shots_held", shots, 1);
    shoot_at(3, 3);
    shoot_at(0, 0);
    shoot_at(4, 4);
    shoot_at(1, 2);
    for (int i = 0; i < 10; i++) press(1, 0, 0, 1, i[0]);
    idle(2);
    chk("done_win", win, 1);
    chk("done_over", game_over, 1);
    chk("done_row_frozen", row, m_row);
    chk("done_col_frozen", col, m_col);
    chk("done_shots", shots, 5);

    // Fifteen misses
    do_reset();
    clear_ships();
    for (int c = 0; c < SHIPS; c++) ship[4 * COLS + c] = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++) shoot_at(r, c);
    chk("lose_over", game_over, 1);
    chk("lose_win", win, 0);
    chk("lose_shots", shots, MAXS);
    chk("lose_hits", hits, 0);

    // Reset during RESP
    do_reset();
    clear_ships();
    ship[1 * COLS + 1] = 1;
    goto_cell(1, 1);
    press(0, 0, 0, 0, 1);
    idle(1);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fire", fire, 0);
    chk("mid_rst_shots", shots, 0);
    chk("mid_rst_hits", hits, 0);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_last_hit", last_hit, 0);
    shoot_at(1, 1);

    // Random games
    for (int g = 0; g < 6; g++) begin
      do_reset();
      clear_ships();
      k = 0;
      while (k < SHIPS) begin
        idx = $urandom_range(0, CELLS - 1);
        if (!ship[idx]) begin ship[idx] = 1; k++; end
      end
      for (int i = 0; i < 300; i++)
        press($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0);
      idle(3);
      chk("rand_row", row, m_row);
      chk("rand_col", col, m_col);
      chk("rand_over", game_over, m_done);
      chk("rand_shots", shots, m_shots);
    end

    idle(3);
    chk("fire_q_drained", fire_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    chk("rep_q_drained", rep_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
